pulp_clock_gate_ctrl: RTL and testbench
=======================================

// Module: pulp_clock_gate_ctrl
// PURPOSE
//   Sequential controller that generates the enable feeding a clock-gate / clock-AND cell.
//   It watches a domain's idle indication and gates the clock after a programmable
//   hysteresis. On wake-up it re-enables the clock and signals readiness after a
//   programmable settle delay. Sits in the always-on domain next to the gating cell.
// PARAMETERS
//   IDLE_CYCLES  4  consecutive qualifying idle cycles before gating (>=1)
//   WAKE_CYCLES  2  cycles after clock re-enable before ready_o rises (>=0)
// PORTS
//   clk_i       in   1  free-running (ungated) clock
//   rst_ni      in   1  asynchronous reset, active low
//   test_en_i   in   1  DFT override; forces clk_en_o=1
//   enable_i    in   1  gating feature enable; 0 = clock never gated
//   idle_i      in   1  gated domain reports idle (sync to clk_i)
//   wake_i      in   1  wake request (sync to clk_i)
//   clk_en_o    out  1  enable to the clock-gating cell
//   gated_o     out  1  status: clock currently gated
//   ready_o     out  1  gated domain clocked and settled
// BEHAVIOUR
//   - Reset (async, rst_ni=0): state RUN, counters 0, clk_en_o=1, gated_o=0, ready_o=1.
//     Reset mid-GATED/WAKE returns to RUN immediately; no wake delay applies.
//   - qual = enable_i & idle_i & ~wake_i (qualifying idle cycle).
//   - States (registered FSM, all outputs from flops except the test_en_i OR):
//     RUN : en_q=1, gated=0, ready=1. On qual, cnt++. On ~qual, cnt<=0.
//           When qual && cnt==IDLE_CYCLES-1 -> GATED, cnt<=0.
//           clk_en_o falls on the edge that samples the IDLE_CYCLES-th consecutive qual.
//     GATED: en_q=0, gated=1, ready=0. If wake_i | ~idle_i | ~enable_i:
//           -> WAKE if WAKE_CYCLES>0, else -> RUN directly.
//     WAKE: en_q=1, gated=0, ready=0; cnt++ each cycle. When cnt==WAKE_CYCLES-1
//           -> RUN, cnt<=0, ready=1 on that edge. idle_i/wake_i ignored in WAKE;
//           the settle sequence always completes.
//   - clk_en_o = en_q | test_en_i (only combinational path). test_en_i does not alter
//     the FSM or gated_o/ready_o.
//   - Priority in RUN: wake_i or ~enable_i clears cnt even if idle_i=1.
//   - enable_i dropping while GATED counts as a wake.
//   - Counter width: $clog2(max(IDLE_CYCLES,WAKE_CYCLES)+1). Shared counter
//     (only one state counts at a time); never wraps.
//   - Latency: idle->gate = IDLE_CYCLES edges; wake->clk_en_o=1 = 1 edge;
//     wake->ready_o=1 = 1+WAKE_CYCLES edges.
//   - Elaboration error if IDLE_CYCLES<1.
// TESTING
//   1 Reset: rst_ni=0 async mid-cycle -> clk_en_o=1, gated_o=0, ready_o=1 immediately.
//   2 Gate: enable_i=1, idle_i=1 from edge 0, defaults -> clk_en_o=0, gated_o=1 after
//     edge 3 (4th sample); idle_i dropped for 1 cycle at edge 2 -> count restarts,
//     gate after edge 6.
//   3 Wake: in GATED pulse wake_i 1 cycle -> clk_en_o=1 after next edge, ready_o=1
//     two edges later (WAKE_CYCLES=2); idle_i=1 during WAKE does not regate early.
//   4 WAKE_CYCLES=0 build: wake_i in GATED -> clk_en_o=1 and ready_o=1 on same edge.
//   5 DFT: test_en_i=1 while GATED -> clk_en_o=1 combinationally, gated_o stays 1;
//     release -> clk_en_o=0.
//   6 Disable: enable_i=0 with idle_i=1 for 20 cycles -> never gates; enable_i 1->0
//     while GATED -> WAKE sequence.

Source files
------------

// File: rtl/pulp_clock_gate_ctrl.sv
// Clock-gate enable controller: gates a domain after sustained idle,
// re-enables on wake and reports readiness after a settle delay.
module pulp_clock_gate_ctrl #(
  parameter int IDLE_CYCLES = 4,
  parameter int WAKE_CYCLES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic test_en_i,
  input  logic enable_i,
  input  logic idle_i,
  input  logic wake_i,
  output logic clk_en_o,
  output logic gated_o,
  output logic ready_o
);

  localparam int MAXC =
    (IDLE_CYCLES > WAKE_CYCLES) ? IDLE_CYCLES : WAKE_CYCLES;
  localparam int CW =
    (MAXC < 1) ? 1 : $clog2(MAXC + 1);
  localparam logic [CW-1:0] IDLE_LAST =
    CW'((IDLE_CYCLES > 0) ? IDLE_CYCLES - 1 : 0);
  localparam logic [CW-1:0] WAKE_LAST =
    CW'((WAKE_CYCLES > 0) ? WAKE_CYCLES - 1 : 0);

  if (IDLE_CYCLES < 1) begin : g_bad_idle
    $error("IDLE_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    GATED = 2'd1,
    WAKE  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          en_q, gated_q, ready_q;
  logic          qual;
  logic          leave;

  assign qual  = enable_i & idle_i & ~wake_i;
  assign leave = wake_i | ~idle_i | ~enable_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      RUN: begin
        if (!qual) begin
          cnt_d = '0;
        end else if (cnt_q == IDLE_LAST) begin
          state_d = GATED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      GATED: begin
        cnt_d = '0;
        if (leave) begin
          state_d = (WAKE_CYCLES > 0) ? WAKE : RUN;
        end
      end
      WAKE: begin
        // settle always runs to completion
        if (cnt_q == WAKE_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RUN;
      cnt_q   <= '0;
      en_q    <= 1'b1;
      gated_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      en_q    <= (state_d != GATED);
      gated_q <= (state_d == GATED);
      ready_q <= (state_d == RUN);
    end
  end

  assign clk_en_o = en_q | test_en_i;
  assign gated_o  = gated_q;
  assign ready_o  = ready_q;

endmodule

// File: tb/tb_pulp_clock_gate_ctrl.sv
// Directed bench for pulp_clock_gate_ctrl: default build plus a
// WAKE_CYCLES=0 build driven by the same stimulus.
module tb_pulp_clock_gate_ctrl;

  logic clk;
  logic rst_n;
  logic test_en;
  logic enable;
  logic idle;
  logic wake;

  logic en_a, gated_a, ready_a;
  logic en_b, gated_b, ready_b;

  int checks;
  int errors;

  pulp_clock_gate_ctrl #(
    .IDLE_CYCLES(4),
    .WAKE_CYCLES(2)
  ) u_dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .test_en_i(test_en),
    .enable_i (enable),
    .idle_i   (idle),
    .wake_i   (wake),
    .clk_en_o (en_a),
    .gated_o  (gated_a),
    .ready_o  (ready_a)
  );

  pulp_clock_gate_ctrl #(
    .IDLE_CYCLES(4),
    .WAKE_CYCLES(0)
  ) u_dut0 (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .test_en_i(test_en),
    .enable_i (enable),
    .idle_i   (idle),
    .wake_i   (wake),
    .clk_en_o (en_b),
    .gated_o  (gated_b),
    .ready_o  (ready_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic obs,
                     input logic exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%b expected=%b",
               tag, obs, exp);
      end
  endtask

  task automatic chk_a(input string tag,
                       input logic e,
                       input logic g,
                       input logic r);
    chk({tag, ".en"}, en_a, e);
    chk({tag, ".gated"}, gated_a, g);
    chk({tag, ".ready"}, ready_a, r);
  endtask

  task automatic chk_b(input string tag,
                       input logic e,
                       input logic g,
                       input logic r);
    chk({tag, ".en0"}, en_b, e);
    chk({tag, ".gated0"}, gated_b, g);
    chk({tag, ".ready0"}, ready_b, r);
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst_n   = 1'b0;
    test_en = 1'b0;
    enable  = 1'b0;
    idle    = 1'b0;
    wake    = 1'b0;

    tick();
    tick();
    chk_a("rst", 1'b1, 1'b0, 1'b1);
    chk_b("rst", 1'b1, 1'b0, 1'b1);
    rst_n = 1'b1;
    tick();

    // basic gate: 4 consecutive qualifying samples
    enable = 1'b1;
    idle   = 1'b1;
    tick();
    chk_a("gate.e0", 1'b1, 1'b0, 1'b1);
    tick();
    tick();
    chk_a("gate.e2", 1'b1, 1'b0, 1'b1);
    tick();
    chk_a("gate.e3", 1'b0, 1'b1, 1'b0);
    chk_b("gate.e3", 1'b0, 1'b1, 1'b0);

    // wake pulse
    wake = 1'b1;
    tick();
    wake = 1'b0;
    chk_a("wake.e1", 1'b1, 1'b0, 1'b0);
    chk_b("wake.e1", 1'b1, 1'b0, 1'b1);
    tick();
    chk_a("wake.e2", 1'b1, 1'b0, 1'b0);
    tick();
    chk_a("wake.e3", 1'b1, 1'b0, 1'b1);
    tick();
    tick();
    tick();
    chk_a("wake.noregate", 1'b1, 1'b0, 1'b1);
    tick();
    chk_a("wake.regate", 1'b0, 1'b1, 1'b0);

    // resync both builds in RUN
    idle = 1'b0;
    tick();
    tick();
    tick();
    chk_a("resync", 1'b1, 1'b0, 1'b1);
    chk_b("resync", 1'b1, 1'b0, 1'b1);

    // idle glitch restarts the count
    idle = 1'b1;
    tick();
    tick();
    idle = 1'b0;
    tick();
    idle = 1'b1;
    tick();
    tick();
    tick();
    chk_a("restart.e5", 1'b1, 1'b0, 1'b1);
    tick();
    chk_a("restart.e6", 1'b0, 1'b1, 1'b0);
    chk_b("restart.e6", 1'b0, 1'b1, 1'b0);

    // DFT override is purely combinational
    #2;
    test_en = 1'b1;
    #1;
    chk_a("dft.on", 1'b1, 1'b1, 1'b0);
    tick();
    chk_a("dft.hold", 1'b1, 1'b1, 1'b0);
    test_en = 1'b0;
    #1;
    chk_a("dft.off", 1'b0, 1'b1, 1'b0);

    // enable dropping while gated acts as wake
    enable = 1'b0;
    tick();
    chk_a("dis.e1", 1'b1, 1'b0, 1'b0);
    chk_b("dis.e1", 1'b1, 1'b0, 1'b1);
    tick();
    chk_a("dis.e2", 1'b1, 1'b0, 1'b0);
    tick();
    chk_a("dis.e3", 1'b1, 1'b0, 1'b1);

    // disabled with idle high never gates
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("dis.never", gated_a, 1'b0);
    end
    chk_b("dis.end", 1'b1, 1'b0, 1'b1);

    // wake held in RUN blocks the count
    enable = 1'b1;
    wake   = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
    end
    chk_a("wakehold", 1'b1, 1'b0, 1'b1);
    wake = 1'b0;
    tick();
    tick();
    tick();
    chk_a("wakehold.e2", 1'b1, 1'b0, 1'b1);
    tick();
    chk_a("wakehold.e3", 1'b0, 1'b1, 1'b0);

    // async reset mid-cycle while gated
    #3;
    rst_n = 1'b0;
    #1;
    chk_a("arst", 1'b1, 1'b0, 1'b1);
    chk_b("arst", 1'b1, 1'b0, 1'b1);
    tick();
    rst_n = 1'b1;
    idle  = 1'b0;
    tick();
    chk_a("arst.rel", 1'b1, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
